// File: rtl/jk_mod_counter_pkg.sv
// Shared JK excitation codes and the single-bit JK next-state function for jk_mod_counter.
package jk_mod_counter_pkg;

  typedef logic [1:0] jk_code_t;

  // Encoding is {J,K}
  localparam jk_code_t JK_HOLD = 2'b00;
  localparam jk_code_t JK_CLR  = 2'b01;
  localparam jk_code_t JK_SET  = 2'b10;
  localparam jk_code_t JK_TOG  = 2'b11;

  function automatic logic jk_next(input logic q, input jk_code_t jk);
    logic nq;
    nq = q;
    case (jk)
      JK_HOLD: nq = q;
      JK_CLR:  nq = 1'b0;
      JK_SET:  nq = 1'b1;
      JK_TOG:  nq = ~q;
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control/status bundle of jk_mod_counter; load and din exist only when JK_CNT_LOAD_EN is defined.
interface jk_mod_counter_if #(
  parameter int unsigned WIDTH = 4
);

  logic             en;
  logic             up_dn;
  logic             clr;
`ifdef JK_CNT_LOAD_EN
  logic             load;
  logic [WIDTH-1:0] din;
`endif
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_bar;
  logic             tc;
  logic             wrap;

`ifdef JK_CNT_LOAD_EN
  modport master (output en, up_dn, clr, load, din,
                  input  count, count_bar, tc, wrap);
  modport slave  (input  en, up_dn, clr, load, din,
                  output count, count_bar, tc, wrap);
`else
  modport master (output en, up_dn, clr,
                  input  count, count_bar, tc, wrap);
  modport slave  (input  en, up_dn, clr,
                  output count, count_bar, tc, wrap);
`endif

endinterface

// File: rtl/jk_ff_cell.sv
// Single JK flip-flop with asynchronous active-high reset to q=0.
module jk_ff_cell
  import jk_mod_counter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);

  logic q_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_r <= 1'b0;
    else       q_r <= jk_next(q_r, {j, k});
  end

  assign q     = q_r;
  assign q_bar = ~q_r;

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-MODULUS counter built from WIDTH JK cells with excitation logic and a wrap strobe.
// Optional parallel load path enabled by defining JK_CNT_LOAD_EN.
module jk_mod_counter
  import jk_mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic           clk,
  input  logic           reset,
  jk_mod_counter_if.slave bus
);

  if (MODULUS < 2 || 64'(MODULUS) > (64'(1) << WIDTH)) begin : g_bad_modulus
    $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  jk_code_t         jk [WIDTH];
  logic             at_max;
  logic             at_zero;
  logic             load_act;
  logic             wrap_nxt;
  logic             wrap_q;

  assign at_max  = (q == MAX_CNT);
  assign at_zero = (q == '0);

`ifdef JK_CNT_LOAD_EN
  logic [WIDTH-1:0] ld_val;

  // Out-of-range load values saturate to the top of the count range
  assign ld_val   = (32'(bus.din) >= MODULUS) ? MAX_CNT : bus.din;
  assign load_act = bus.load;
`else
  assign load_act = 1'b0;
`endif

  // Per-bit excitation; priority clr > load > en > hold
  always_comb begin
    logic up_carry;
    logic dn_carry;
    up_carry = 1'b1;
    dn_carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      jk[i] = JK_HOLD;
      if (bus.clr) begin
        jk[i] = JK_CLR;
      end
`ifdef JK_CNT_LOAD_EN
      else if (bus.load) begin
        jk[i] = {ld_val[i], ~ld_val[i]};
      end
`endif
      else if (bus.en) begin
        if (bus.up_dn) begin
          if (at_max) jk[i] = q[i] ? JK_CLR : JK_HOLD;
          else        jk[i] = up_carry ? JK_TOG : JK_HOLD;
        end else begin
          if (at_zero) jk[i] = {MAX_CNT[i], ~MAX_CNT[i]};
          else         jk[i] = dn_carry ? JK_TOG : JK_HOLD;
        end
      end
      up_carry = up_carry & q[i];
      dn_carry = dn_carry & ~q[i];
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    assign j[gi] = jk[gi][1];
    assign k[gi] = jk[gi][0];

    jk_ff_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j[gi]),
      .k     (k[gi]),
      .q     (q[gi]),
      .q_bar (q_bar[gi])
    );
  end

  assign wrap_nxt = bus.en & ~bus.clr & ~load_act & (bus.up_dn ? at_max : at_zero);

  // Wrap strobe is high during the cycle that follows a wrapping edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wrap_q <= 1'b0;
    else       wrap_q <= wrap_nxt;
  end

  assign bus.count     = q;
  assign bus.count_bar = q_bar;
  assign bus.tc        = bus.en & (bus.up_dn ? at_max : at_zero);
  assign bus.wrap      = wrap_q;

endmodule
